voq_ingress_writer: RTL and testbench
=====================================

// Module: voq_ingress_writer
// PURPOSE
// Parametrised ingress stage of the switch: accepts packet words per input port over the Avalon-MM slave and
// steers each packet into the virtual output queue (VOQ) RAM for its (input, output) pair.
// Adds over the fixed 4x4 writer: per-VOQ full detection, whole-packet drop with pointer rollback,
// packet commit to the scheduler, per-input drop counters and status readback. VOQ RAMs sit outside the block.
// PARAMETERS
// N_PORTS  4     input ports = output ports; range 2..8; DW_P = max(1,$clog2(N_PORTS))
// DATA_W   32    stored word width, range 8..32; uses writedata[DATA_W-1:0]
// DEPTH    4096  words per VOQ RAM, power of 2; AW = $clog2(DEPTH)
// PORTS
// clk             in   1                  system clock
// reset_n         in   1                  asynchronous, active-low reset
// chipselect      in   1                  Avalon slave select
// write           in   1                  Avalon write strobe
// read            in   1                  Avalon read strobe
// address         in   4                  register/port address
// writedata       in   32                 Avalon write data
// readdata        out  32                 registered read data
// voq_wren        out  N*N                one-cycle write strobe; bit i*N+j = input i, output j
// voq_wr_addr     out  N*N*AW             write address per VOQ
// voq_wr_data     out  N*DATA_W           write data per input, shared by that input's N VOQs
// voq_rd_ptr      in   N*N*(AW+1)         scheduler read pointer per VOQ, wrap bit in MSB
// voq_commit_ptr  out  N*N*(AW+1)         committed write pointer per VOQ; scheduler reads only below it
// voq_commit      out  N*N                one-cycle pulse when a packet is committed
// sched_write_en  out  1                  sticky enable to scheduler
// sched_read_en   out  1                  sticky enable to scheduler
// clear_pulse     out  1                  one-cycle pulse after a clear
// BEHAVIOUR
// - Reset: all outputs 0; internal wr_ptr and commit_ptr 0; all input FSMs IDLE; drop counters 0.
// - Address map, write: 0..N-1 = data word for input p; 13 = clear; 14 = set sched_read_en; 15 = set sched_write_en.
//   Other addresses are ignored.
// - Address map, read, 1-cycle latency: p<N -> {14'b0, state[1:0], drop_cnt[p][15:0]};
//   12 -> {30'b0, sched_write_en, sched_read_en}; other addresses -> 0.
// - Word Z is zero iff writedata[DATA_W-1:0]==0. Zero word = end-of-packet (EOP).
// - Occupancy: used = wr_ptr - voq_rd_ptr, modulo 2^(AW+1). full = (used == DEPTH).
// - Per-input FSM, advanced by accepted data writes (chipselect && write && address==p):
//   IDLE: zero word -> ignored.
//     Nonzero word -> dest = writedata[DW_P-1:0].
//     If VOQ(p,dest) is full -> DROP, drop_cnt++.
//     Otherwise write the word (header) and go to PKT.
//   PKT: word written to VOQ(p,dest).
//     If VOQ(p,dest) is full when the word arrives -> wr_ptr rolls back to commit_ptr, drop_cnt++, go to DROP.
//     On a zero word that is stored: commit_ptr <= wr_ptr+1, voq_commit pulses, go to IDLE.
//   DROP: discard all words; a zero word -> IDLE.
// - Write timing: accepted word appears on voq_wren/voq_wr_addr/voq_wr_data in the next cycle, for one cycle.
//   wr_ptr increments in that same cycle. voq_wr_addr = wr_ptr[AW-1:0] and wraps at DEPTH.
//   voq_commit pulses in the same cycle as the EOP wren.
// - Back-to-back writes to one port every cycle are supported. Different ports are independent;
//   the Avalon bus carries at most one write per cycle.
// - drop_cnt saturates at 16'hFFFF.
// - Clear (address 13): next cycle, all wr_ptr/commit_ptr are 0, FSMs IDLE, drop_cnt 0, sched_*_en 0,
//   voq_wren 0, clear_pulse=1. The clear is a single write, so no data write can coincide with it;
//   an in-flight packet is discarded without a commit.
// - reset_n asserted mid-packet: immediate return to the reset state; the partial packet is never committed.
// TESTING
// - Reset then write port0: 0x6, 0xAAAA, 0x0 -> three wren on bit 2 at addr 0,1,2;
//   voq_commit[2] with commit_ptr 3; state IDLE.
// - Idle zero word on port1: 0x0 -> no wren, no commit, drop_cnt[1]=0.
// - VOQ(0,1) at used=DEPTH-1, send 0x5, 0x1, 0x0 -> header stored, second word finds full -> rollback to old commit_ptr,
//   drop_cnt[0]=1, EOP discarded, no commit.
// - Wrap: wr_ptr=DEPTH-1, rd_ptr=DEPTH-2, 2-word packet -> wr_addr DEPTH-1 then 0; commit_ptr=DEPTH+1.
// - Clear mid-packet on port2 after 2 words -> clear_pulse, all pointers 0, reading addr 2 gives state 0;
//   next packet starts at addr 0.
// - Write 14, 15, then read 12 -> readdata=3; reset_n low mid-packet -> all outputs 0.

Source files
------------

// File: rtl/voq_ingress_writer.sv
// Ingress writer: steers per-input packet words into per-(input,output) VOQ RAMs, commits whole packets, drops on full.
// Latency: accepted word drives voq_wren/addr/data one cycle later; readdata is registered with 1-cycle latency.
// Backpressure: none on the Avalon side; a full VOQ causes the whole packet to be dropped and counted instead.
module voq_ingress_writer #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              chipselect,
  input  logic                                              write,
  input  logic                                              read,
  input  logic [3:0]                                        address,
  input  logic [31:0]                                       writedata,
  output logic [31:0]                                       readdata,
  output logic [N_PORTS*N_PORTS-1:0]                        voq_wren,
  output logic [N_PORTS*N_PORTS*$clog2(DEPTH)-1:0]          voq_wr_addr,
  output logic [N_PORTS*DATA_W-1:0]                         voq_wr_data,
  input  logic [N_PORTS*N_PORTS*($clog2(DEPTH)+1)-1:0]      voq_rd_ptr,
  output logic [N_PORTS*N_PORTS*($clog2(DEPTH)+1)-1:0]      voq_commit_ptr,
  output logic [N_PORTS*N_PORTS-1:0]                        voq_commit,
  output logic                                              sched_write_en,
  output logic                                              sched_read_en,
  output logic                                              clear_pulse
);

  localparam int N    = N_PORTS;
  localparam int DW_P = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam logic [DW_P:0] DST_LIM  = (DW_P+1)'(N_PORTS);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PKT = 2'd1, S_DROP = 2'd2} state_t;

  state_t            state_q    [N];
  logic [DW_P-1:0]   dest_q     [N];
  logic [15:0]       drop_q     [N];
  logic [DATA_W-1:0] wdata_q    [N];
  logic [AW:0]       wr_ptr_q   [N][N];
  logic [AW:0]       commit_q   [N][N];
  logic [AW-1:0]     waddr_q    [N][N];
  logic              wren_q     [N][N];
  logic              commit_p_q [N][N];
  logic [AW:0]       rd_ptr     [N][N];

  logic            data_wr;
  logic            clear_wr;
  logic [DW_P-1:0] wp;
  state_t          cur_state;
  logic            word_zero;
  logic [DW_P-1:0] sel_dest;
  logic            dest_ok;
  logic [DW_P-1:0] sel_idx;
  logic [AW:0]     sel_wr;
  logic [AW:0]     sel_wr_inc;
  logic [AW:0]     sel_cp;
  logic [AW:0]     sel_used;
  logic            sel_full;
  logic [15:0]     drop_next;

  // Flatten internal per-VOQ arrays onto the packed output buses and unpack read pointers.
  for (genvar gi = 0; gi < N; gi++) begin : g_in
    assign voq_wr_data[gi*DATA_W +: DATA_W] = wdata_q[gi];
    for (genvar gj = 0; gj < N; gj++) begin : g_out
      localparam int K = gi*N + gj;
      assign voq_wren[K]                 = wren_q[gi][gj];
      assign voq_commit[K]               = commit_p_q[gi][gj];
      assign voq_wr_addr[K*AW +: AW]     = waddr_q[gi][gj];
      assign voq_commit_ptr[K*PW +: PW]  = commit_q[gi][gj];
      assign rd_ptr[gi][gj]              = voq_rd_ptr[K*PW +: PW];
    end
  end

  assign data_wr  = chipselect && write && (address < 4'(N_PORTS));
  assign clear_wr = chipselect && write && (address == 4'd13);

  // Decode the addressed input's target VOQ and its occupancy for the word being accepted.
  always_comb begin
    wp         = address[DW_P-1:0];
    cur_state  = state_q[wp];
    word_zero  = (writedata[DATA_W-1:0] == '0);
    // The header carries the destination; later words reuse the latched one.
    sel_dest   = (cur_state == S_IDLE) ? writedata[DW_P-1:0] : dest_q[wp];
    // Destinations beyond N_PORTS-1 (possible for non-power-of-2 N) have no VOQ.
    dest_ok    = ({1'b0, sel_dest} < DST_LIM);
    sel_idx    = dest_ok ? sel_dest : '0;
    sel_wr     = wr_ptr_q[wp][sel_idx];
    sel_wr_inc = sel_wr + {{AW{1'b0}}, 1'b1};
    sel_cp     = commit_q[wp][sel_idx];
    sel_used   = sel_wr - rd_ptr[wp][sel_idx];
    sel_full   = (sel_used == FULL_LVL);
    drop_next  = (drop_q[wp] == 16'hFFFF) ? drop_q[wp] : drop_q[wp] + 16'd1;
  end

  // Per-input packet FSMs, VOQ write/commit pointers, write strobes, drop counters and control flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_IDLE;
        dest_q[i]  <= '0;
        drop_q[i]  <= '0;
        wdata_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          wr_ptr_q[i][j]   <= '0;
          commit_q[i][j]   <= '0;
          waddr_q[i][j]    <= '0;
          wren_q[i][j]     <= 1'b0;
          commit_p_q[i][j] <= 1'b0;
        end
      end
      sched_write_en <= 1'b0;
      sched_read_en  <= 1'b0;
      clear_pulse    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          wren_q[i][j]     <= 1'b0;
          commit_p_q[i][j] <= 1'b0;
        end
      end
      clear_pulse <= 1'b0;
      if (clear_wr) begin
        // Any in-flight packet is abandoned: pointers return to 0 without a commit.
        for (int i = 0; i < N; i++) begin
          state_q[i] <= S_IDLE;
          drop_q[i]  <= '0;
          for (int j = 0; j < N; j++) begin
            wr_ptr_q[i][j] <= '0;
            commit_q[i][j] <= '0;
          end
        end
        sched_write_en <= 1'b0;
        sched_read_en  <= 1'b0;
        clear_pulse    <= 1'b1;
      end else begin
        if (chipselect && write && address == 4'd14) sched_read_en  <= 1'b1;
        if (chipselect && write && address == 4'd15) sched_write_en <= 1'b1;
        if (data_wr) begin
          case (cur_state)
            S_IDLE: begin
              if (!word_zero) begin
                if (!dest_ok || sel_full) begin
                  state_q[wp] <= S_DROP;
                  drop_q[wp]  <= drop_next;
                end else begin
                  wren_q[wp][sel_idx]   <= 1'b1;
                  waddr_q[wp][sel_idx]  <= sel_wr[AW-1:0];
                  wr_ptr_q[wp][sel_idx] <= sel_wr_inc;
                  wdata_q[wp]           <= writedata[DATA_W-1:0];
                  dest_q[wp]            <= sel_dest;
                  state_q[wp]           <= S_PKT;
                end
              end
            end
            S_PKT: begin
              if (sel_full) begin
                // Unwind the partial packet so the scheduler never sees it.
                wr_ptr_q[wp][sel_idx] <= sel_cp;
                drop_q[wp]            <= drop_next;
                state_q[wp]           <= S_DROP;
              end else begin
                wren_q[wp][sel_idx]   <= 1'b1;
                waddr_q[wp][sel_idx]  <= sel_wr[AW-1:0];
                wr_ptr_q[wp][sel_idx] <= sel_wr_inc;
                wdata_q[wp]           <= writedata[DATA_W-1:0];
                if (word_zero) begin
                  commit_q[wp][sel_idx]   <= sel_wr_inc;
                  commit_p_q[wp][sel_idx] <= 1'b1;
                  state_q[wp]             <= S_IDLE;
                end
              end
            end
            S_DROP: begin
              if (word_zero) state_q[wp] <= S_IDLE;
            end
            default: state_q[wp] <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Registered status readback: per-input state/drop count, scheduler enables, zero elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      if (address < 4'(N_PORTS))
        readdata <= {14'b0, state_q[address[DW_P-1:0]], drop_q[address[DW_P-1:0]]};
      else if (address == 4'd12)
        readdata <= {30'b0, sched_write_en, sched_read_en};
      else
        readdata <= '0;
    end else begin
      readdata <= '0;
    end
  end

endmodule

// File: tb/tb_voq_ingress_writer.sv
module tb_voq_ingress_writer;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 4;
  localparam int PW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [3:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [N*N-1:0]    voq_wren;
  logic [N*N*AW-1:0] voq_wr_addr;
  logic [N*DW-1:0]   voq_wr_data;
  logic [N*N*PW-1:0] voq_rd_ptr = '0;
  logic [N*N*PW-1:0] voq_commit_ptr;
  logic [N*N-1:0]    voq_commit;
  logic              sched_write_en;
  logic              sched_read_en;
  logic              clear_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  voq_ingress_writer #(.N_PORTS(N), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .voq_wren(voq_wren), .voq_wr_addr(voq_wr_addr), .voq_wr_data(voq_wr_data),
    .voq_rd_ptr(voq_rd_ptr), .voq_commit_ptr(voq_commit_ptr), .voq_commit(voq_commit),
    .sched_write_en(sched_write_en), .sched_read_en(sched_read_en), .clear_pulse(clear_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] wren;
    logic [15:0] commit;
    int          k;
    logic [3:0]  waddr;
    logic [4:0]  cptr;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the result visible.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [4:0] v);
    voq_rd_ptr[k*PW +: PW] = v;
  endtask

  function automatic logic [3:0] waddr_of(input int k);
    return voq_wr_addr[k*AW +: AW];
  endfunction

  function automatic logic [4:0] cptr_of(input int k);
    return voq_commit_ptr[k*PW +: PW];
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  32'h6,    16'h0004, 16'h0000, 2,  4'd0, 5'd0, 32'h0};
    vecs[1]  = '{1'b0, 4'd0,  32'hAAAA, 16'h0004, 16'h0000, 2,  4'd1, 5'd0, 32'h0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,    16'h0004, 16'h0004, 2,  4'd2, 5'd3, 32'h0};
    vecs[3]  = '{1'b1, 4'd0,  32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};
    vecs[4]  = '{1'b0, 4'd1,  32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};
    vecs[5]  = '{1'b1, 4'd1,  32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};
    vecs[6]  = '{1'b0, 4'd3,  32'h1,    16'h2000, 16'h0000, 13, 4'd0, 5'd0, 32'h0};
    vecs[7]  = '{1'b0, 4'd2,  32'h3,    16'h0800, 16'h0000, 11, 4'd0, 5'd0, 32'h0};
    vecs[8]  = '{1'b0, 4'd3,  32'h0,    16'h2000, 16'h2000, 13, 4'd1, 5'd2, 32'h0};
    vecs[9]  = '{1'b1, 4'd2,  32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0001_0000};
    vecs[10] = '{1'b0, 4'd2,  32'h0,    16'h0800, 16'h0800, 11, 4'd1, 5'd2, 32'h0};
    vecs[11] = '{1'b0, 4'd9,  32'h5,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};
    vecs[12] = '{1'b1, 4'd12, 32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};
    vecs[13] = '{1'b1, 4'd3,  32'h0,    16'h0000, 16'h0000, -1, 4'd0, 5'd0, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wren", voq_wren, 0);
    chk("rst_commit", voq_commit, 0);
    chk("rst_cptr", voq_commit_ptr, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_sched", {sched_write_en, sched_read_en, clear_pulse}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: back-to-back accesses, one per cycle
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_rd) begin
        rd(vecs[i].addr);
        chk($sformatf("v%0d_rdata", i), readdata, vecs[i].rdat);
      end else begin
        wr(vecs[i].addr, vecs[i].data);
        chk($sformatf("v%0d_wren", i), voq_wren, vecs[i].wren);
        chk($sformatf("v%0d_commit", i), voq_commit, vecs[i].commit);
        if (vecs[i].k >= 0) begin
          chk($sformatf("v%0d_waddr", i), waddr_of(vecs[i].k), vecs[i].waddr);
          chk($sformatf("v%0d_cptr", i), cptr_of(vecs[i].k), vecs[i].cptr);
          chk($sformatf("v%0d_wdata", i), voq_wr_data[vecs[i].addr*DW +: DW], vecs[i].data);
        end
      end
    end

    // Full mid-packet on VOQ(0,1): used = 0 - 17 = DEPTH-1
    set_rd(1, 5'd17);
    wr(0, 32'h5);  chk("full_hdr_wren", voq_wren, 16'h0002);
    chk("full_hdr_addr", waddr_of(1), 0);
    wr(0, 32'h1);  chk("full_w2_wren", voq_wren, 0);
    wr(0, 32'h0);  chk("full_eop_wren", voq_wren, 0);
    chk("full_eop_commit", voq_commit, 0);
    chk("full_cptr", cptr_of(1), 0);
    rd(0);         chk("full_drop_cnt", readdata, 32'h1);
    set_rd(1, 5'd0);
    wr(0, 32'h1);  chk("rollback_addr0", waddr_of(1), 0);
    wr(0, 32'h0);  chk("rollback_addr1", waddr_of(1), 1);
    chk("rollback_commit", voq_commit, 16'h0002);
    chk("rollback_cptr", cptr_of(1), 2);

    // Full at header on VOQ(1,0): whole packet dropped from IDLE
    set_rd(4, 5'd16);
    wr(1, 32'h4);  chk("idrop_hdr_wren", voq_wren, 0);
    wr(1, 32'h7);  chk("idrop_body_wren", voq_wren, 0);
    rd(1);         chk("idrop_status", readdata, 32'h0002_0001);
    wr(1, 32'h0);
    rd(1);         chk("idrop_idle", readdata, 32'h1);
    set_rd(4, 5'd0);

    // Address wrap on VOQ(3,0)
    wr(3, 32'h4);  chk("wrap_fill_hdr", waddr_of(12), 0);
    for (int i = 0; i < 13; i++) wr(3, 32'h10 + i);
    wr(3, 32'h0);  chk("wrap_fill_eop", waddr_of(12), 14);
    chk("wrap_fill_cptr", cptr_of(12), 15);
    set_rd(12, 5'd14);
    wr(3, 32'h4);  chk("wrap_hdr_addr", waddr_of(12), 15);
    chk("wrap_hdr_wren", voq_wren, 16'h1000);
    wr(3, 32'h0);  chk("wrap_eop_addr", waddr_of(12), 0);
    chk("wrap_commit", voq_commit, 16'h1000);
    chk("wrap_cptr", cptr_of(12), 5'd17);

    // Clear mid-packet on port 2
    wr(2, 32'h2);  chk("clr_w0", waddr_of(10), 0);
    wr(2, 32'h9);  chk("clr_w1", waddr_of(10), 1);
    rd(2);         chk("clr_state_pkt", readdata, 32'h0001_0000);
    wr(13, 32'h0); chk("clr_pulse", clear_pulse, 1);
    chk("clr_wren", voq_wren, 0);
    chk("clr_commit", voq_commit, 0);
    chk("clr_cptr_all", voq_commit_ptr, 0);
    rd(2);         chk("clr_state", readdata, 0);
    chk("clr_pulse_gone", clear_pulse, 0);
    rd(0);         chk("clr_drop_cnt", readdata, 0);
    wr(2, 32'h2);  chk("clr_restart", waddr_of(10), 0);
    wr(2, 32'h0);  chk("clr_commit_new", voq_commit, 16'h0400);
    chk("clr_cptr_new", cptr_of(10), 2);

    // Scheduler enables, then reset mid-packet
    wr(14, 32'h0);
    wr(15, 32'h0);
    rd(12);        chk("sched_en", readdata, 32'h3);
    wr(1, 32'h1);  chk("mid_wren", voq_wren, 16'h0020);
    reset_n = 1'b0;
    #1;
    chk("arst_wren", voq_wren, 0);
    chk("arst_cptr", voq_commit_ptr, 0);
    chk("arst_waddr", voq_wr_addr, 0);
    chk("arst_wdata", voq_wr_data, 0);
    chk("arst_flags", {sched_write_en, sched_read_en, clear_pulse, voq_commit}, 0);
    chk("arst_rdata", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(1);         chk("arst_state", readdata, 0);
    wr(1, 32'h1);  chk("arst_restart0", waddr_of(5), 0);
    wr(1, 32'h0);  chk("arst_restart1", waddr_of(5), 1);
    chk("arst_commit", cptr_of(5), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
